// File: rtl/vga_rect_fill.sv
// vga_rect_fill: row-wise read-modify-write rectangle fill for the framebuffer; XOR mode built only with VGA_RECT_FILL_XOR_EN
module vga_rect_fill #(
    parameter int ROWS = 480,
    parameter int COLS = 480
) (
    input  logic            clk_50,
    input  logic            rst,
    input  logic [15:0]     DEVICE,
    input  logic [15:0]     DATA,
    input  logic [COLS-1:0] ram_480_480_dout_rw,
    output logic [8:0]      ram_480_480_address_rw,
    output logic [COLS-1:0] ram_480_480_din,
    output logic            ram_480_480_write,
    output logic            busy,
    output logic            done
);
    localparam logic [8:0] X_MAX = 9'(COLS - 1);
    localparam logic [8:0] Y_MAX = 9'(ROWS - 1);

    typedef enum logic [2:0] {S_IDLE, S_REJECT, S_ADDR, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t          r_state, w_state_n;
    logic [8:0]      r_x0, r_x1, r_y0, r_y1, r_row;
    logic            r_colour, r_start_d;
    logic [COLS-1:0] r_mask, r_din, w_mask, w_row;
    logic            w_start, w_bad, w_unused;
`ifdef VGA_RECT_FILL_XOR_EN
    logic            r_xor;
`endif

    function automatic logic [8:0] clamp(input logic [8:0] v, input logic [8:0] m);
        return (v > m) ? m : v;
    endfunction

    assign w_start = (DEVICE == 16'h0035) && !r_start_d;
    assign w_bad   = (r_x0 > r_x1) || (r_y0 > r_y1);

    for (genvar i = 0; i < COLS; i++) begin : g_mask
        assign w_mask[i] = (r_x0 <= 9'(i)) && (9'(i) <= r_x1);
    end

`ifdef VGA_RECT_FILL_XOR_EN
    assign w_row    = r_xor    ? (ram_480_480_dout_rw ^ r_mask) :
                      r_colour ? (ram_480_480_dout_rw | r_mask) : (ram_480_480_dout_rw & ~r_mask);
    assign w_unused = &{1'b0, DATA[15:9]};
`else
    assign w_row    = r_colour ? (ram_480_480_dout_rw | r_mask) : (ram_480_480_dout_rw & ~r_mask);
    assign w_unused = &{1'b0, DATA[15:9], DATA[1]};
`endif

    assign ram_480_480_address_rw = r_row;
    assign ram_480_480_din        = r_din;

    // state register
    always_ff @(posedge clk_50) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_n;
    end

    // next state and port-control outputs; busy covers only the RAM-owning states
    always_comb begin
        w_state_n         = r_state;
        busy              = 1'b0;
        done              = 1'b0;
        ram_480_480_write = 1'b0;
        case (r_state)
            S_IDLE:   if (w_start) w_state_n = w_bad ? S_REJECT : S_ADDR;
            S_REJECT: begin
                done      = 1'b1;
                w_state_n = S_IDLE;
            end
            S_ADDR:   begin
                busy      = 1'b1;
                w_state_n = S_WAIT;
            end
            S_WAIT:   begin
                busy      = 1'b1;
                w_state_n = S_WRITE;
            end
            S_WRITE:  begin
                busy              = 1'b1;
                ram_480_480_write = 1'b1;
                w_state_n         = (r_row == r_y1) ? S_DONE : S_ADDR;
            end
            S_DONE:   begin
                done      = 1'b1;
                w_state_n = S_IDLE;
            end
            default:  w_state_n = S_IDLE;
        endcase
    end

    // command registers, row counter, latched mask and write data captured while dout is valid in WAIT
    always_ff @(posedge clk_50) begin
        if (rst) begin
            r_x0      <= '0;
            r_x1      <= X_MAX;
            r_y0      <= '0;
            r_y1      <= Y_MAX;
            r_colour  <= 1'b0;
            r_start_d <= 1'b0;
            r_row     <= '0;
            r_mask    <= '0;
            r_din     <= '0;
`ifdef VGA_RECT_FILL_XOR_EN
            r_xor     <= 1'b0;
`endif
        end else begin
            r_start_d <= DEVICE == 16'h0035;
            if (!busy) begin
                if (DEVICE == 16'h0030) r_x0 <= clamp(DATA[8:0], X_MAX);
                if (DEVICE == 16'h0031) r_x1 <= clamp(DATA[8:0], X_MAX);
                if (DEVICE == 16'h0032) r_y0 <= clamp(DATA[8:0], Y_MAX);
                if (DEVICE == 16'h0033) r_y1 <= clamp(DATA[8:0], Y_MAX);
                if (DEVICE == 16'h0034) begin
                    r_colour <= DATA[0];
`ifdef VGA_RECT_FILL_XOR_EN
                    r_xor    <= DATA[1];
`endif
                end
            end
            if (r_state == S_IDLE && w_state_n == S_ADDR) begin
                r_row  <= r_y0;
                r_mask <= w_mask;
            end else if (r_state == S_WRITE && w_state_n == S_ADDR) begin
                r_row  <= r_row + 9'd1;
            end
            if (r_state == S_WAIT) r_din <= w_row;
        end
    end
endmodule
